// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared state encodings, access classes and width defaults for the memory request path.
package mem_if_pkg;
  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 13;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  typedef enum logic [1:0] {FETCH, LOAD, STORE} cls_e;
endpackage

// File: rtl/mem_req_arb.sv
// mem_req_arb: 2-way round-robin arbiter between fetch and data requests; last grant starts at data.
module mem_req_arb (
  input  logic clk,
  input  logic reset,
  input  logic fetch_req,
  input  logic data_req,
  input  logic accept,
  output logic grant_fetch,
  output logic grant_data
);
  logic last_data;
  assign grant_fetch = fetch_req & (~data_req | last_data);
  assign grant_data = data_req & (~fetch_req | ~last_data);
  always_ff @(posedge clk)
    if (reset) last_data <= 1'b1;
    else if (accept) last_data <= grant_data;
endmodule

// File: rtl/mem_request_ctrl.sv
// mem_request_ctrl: arbitrated initiator of the memory request/Done handshake.
// Define MEM_TIMEOUT_EN to abort accesses whose Done never arrives.
module mem_request_ctrl
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MEM_DEPTH = 13,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] instr_out,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic              addr_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write,
  output logic              mem_read,
  output logic              mem_instruction,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_data_out
);
  logic [1:0] state;
  cls_e cls, nc;
  logic gf, gd, accept, oor, tmo, finish;
  logic [ADDR_W-1:0] a;
  mem_req_arb u_arb (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .data_req(data_req),
    .accept(accept), .grant_fetch(gf), .grant_data(gd)
  );
  assign accept = (state == IDLE) && (fetch_req || data_req);
  assign nc = gd ? (data_we ? STORE : LOAD) : FETCH;
  assign a = gf ? fetch_addr : data_addr;
  assign oor = a >= ADDR_W'(MEM_DEPTH);
  assign busy = state != IDLE;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  // Done on the expiry edge still counts as a normal completion.
  assign tmo = (state == REQ) && !mem_done && (cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else cnt <= (state == REQ) ? cnt + 1'b1 : '0;
`else
  assign tmo = 1'b0;
`endif
  assign finish = (state == REQ) && (mem_done || tmo);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cls <= FETCH;
      fetch_ack <= 1'b0;
      data_ack <= 1'b0;
      addr_err <= 1'b0;
      instr_out <= '0;
      data_rdata <= '0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_write <= 1'b0;
      mem_read <= 1'b0;
      mem_instruction <= 1'b0;
    end else begin
      fetch_ack <= 1'b0;
      data_ack <= 1'b0;
      addr_err <= 1'b0;
      if (accept) begin
        cls <= nc;
        if (oor) begin
          state <= RESP;
          fetch_ack <= gf;
          data_ack <= gd;
          addr_err <= 1'b1;
          if (gf) instr_out <= '0;
          else if (nc == LOAD) data_rdata <= '0;
        end else begin
          state <= REQ;
          mem_address <= a;
          if (nc == STORE) mem_data_in <= data_wdata;
          mem_read <= nc != STORE;
          mem_write <= nc == STORE;
          mem_instruction <= gf;
        end
      end else if (finish) begin
        state <= RESP;
        mem_read <= 1'b0;
        mem_write <= 1'b0;
        mem_instruction <= 1'b0;
        fetch_ack <= cls == FETCH;
        data_ack <= cls != FETCH;
        addr_err <= !mem_done;
        if (cls == FETCH) instr_out <= mem_done ? mem_data_out : '0;
        else if (cls == LOAD) data_rdata <= mem_done ? mem_data_out : '0;
      end else if (state == RESP) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mem_request_ctrl.sv
// tb_mem_request_ctrl: directed self-checking bench for mem_request_ctrl with a zero-wait memory responder.
module tb_mem_request_ctrl;
  logic clk = 0, reset = 1;
  logic fetch_req = 0, data_req = 0, data_we = 0;
  logic [12:0] fetch_addr = 0, data_addr = 0, data_wdata = 0;
  logic fetch_ack, data_ack, addr_err, busy, mem_write, mem_read, mem_instruction, mem_done;
  logic [12:0] instr_out, data_rdata, mem_address, mem_data_in, mem_data_out;
  logic done_en = 1, done_force = 0;
  logic [12:0] mem [0:15];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mem_request_ctrl dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .instr_out(instr_out), .data_req(data_req), .data_we(data_we),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
    .addr_err(addr_err), .busy(busy), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write(mem_write), .mem_read(mem_read), .mem_instruction(mem_instruction),
    .mem_done(mem_done), .mem_data_out(mem_data_out)
  );

  assign mem_done = done_force | (done_en & (mem_read | mem_write));
  assign mem_data_out = mem[mem_address[3:0]];
  always @(posedge clk) if (mem_write && mem_done) mem[mem_address[3:0]] <= mem_data_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic access(input bit f, input bit we, input logic [12:0] a, input logic [12:0] wd,
                        input logic [12:0] exp, input bit err);
    @(negedge clk);
    fetch_req = f; data_req = !f; data_we = we; fetch_addr = a; data_addr = a; data_wdata = wd;
    @(posedge clk); #1;
    fetch_req = 0; data_req = 0; fetch_addr = 13'h1F0F; data_addr = 13'h1F0F; data_wdata = 13'h0F0F;
    if (!err) begin
      check("busy_req", busy, 1);
      check("mem_read", mem_read, !we);
      check("mem_write", mem_write, we);
      check("mem_instr", mem_instruction, f);
      check("mem_addr", mem_address, a);
      if (we) check("mem_din", mem_data_in, wd);
      @(posedge clk); #1;
    end else check("no_strobes", {mem_read, mem_write, mem_instruction}, 0);
    check("ack", {fetch_ack, data_ack}, f ? 2 : 1);
    check("addr_err", addr_err, err);
    check("strobes_off", {mem_read, mem_write}, 0);
    if (f) check("instr_out", instr_out, exp);
    else if (!we) check("data_rdata", data_rdata, exp);
    @(posedge clk); #1;
    check("ack_off", {fetch_ack, data_ack}, 0);
    check("idle", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 13'(i);
    mem[3] = 13'h0ABC;
    mem[12] = 13'h0777;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_strobes", {mem_read, mem_write, mem_instruction}, 0);
    check("rst_acks", {fetch_ack, data_ack, addr_err}, 0);
    check("rst_instr", instr_out, 0);
    check("rst_rdata", data_rdata, 0);
    check("rst_addr", mem_address, 0);
    check("rst_din", mem_data_in, 0);
    @(negedge clk) reset = 0;
    access(1, 0, 3, 0, 13'h0ABC, 0);
    access(0, 1, 5, 13'h1234, 0, 0);
    access(0, 0, 5, 0, 13'h1234, 0);
    access(0, 0, 12, 0, 13'h0777, 0);
    access(0, 1, 7, 13'h0555, 0, 0);
    check("store_keeps_rdata", data_rdata, 13'h0777);
    check("store_keeps_instr", instr_out, 13'h0ABC);
    access(1, 0, 3, 0, 13'h0ABC, 0);
    // Last grant is now fetch, so simultaneous requests start with data.
    @(negedge clk);
    fetch_req = 1; data_req = 1; data_we = 0; fetch_addr = 3; data_addr = 5;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rr_grant", mem_instruction, i % 2);
      @(posedge clk); #1;
      check("rr_ack", {fetch_ack, data_ack}, (i % 2) ? 2 : 1);
      if (i % 2) check("rr_instr", instr_out, 13'h0ABC);
      else check("rr_rdata", data_rdata, 13'h1234);
      @(posedge clk); #1;
      check("rr_ack_off", {fetch_ack, data_ack}, 0);
    end
    fetch_req = 0; data_req = 0;
    access(0, 0, 13, 0, 0, 1);
    access(1, 0, 13'h1FFF, 0, 0, 1);
    access(0, 1, 13, 13'h0111, 0, 1);
    check("oor_store_no_write", mem[13], 13'd13);
    done_en = 0;
    @(negedge clk);
    fetch_req = 1; fetch_addr = 3;
    @(posedge clk); #1;
    fetch_req = 0;
    check("pre_rst_read", mem_read, 1);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    check("mid_rst_strobes", {mem_read, mem_write, mem_instruction}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_acks", {fetch_ack, data_ack}, 0);
    @(negedge clk) begin reset = 0; done_force = 1; end
    @(negedge clk) done_force = 0;
    check("late_done_ack", {fetch_ack, data_ack}, 0);
    check("late_done_busy", busy, 0);
    check("late_done_instr", instr_out, 0);
    @(negedge clk);
    data_req = 1; data_we = 0; data_addr = 5;
    @(posedge clk); #1;
    data_req = 0;
`ifdef MEM_TIMEOUT_EN
    repeat (7) @(posedge clk);
    #1;
    check("tmo_wait", {busy, mem_read, data_ack}, 3'b110);
    @(posedge clk); #1;
    check("tmo_ack", {data_ack, addr_err, mem_read}, 3'b110);
    check("tmo_rdata", data_rdata, 0);
    @(posedge clk); #1;
    check("tmo_idle", busy, 0);
`else
    repeat (20) @(posedge clk);
    #1;
    check("no_tmo_busy", {busy, mem_read, data_ack, addr_err}, 4'b1100);
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
`endif
    done_en = 1;
    access(0, 0, 5, 0, 13'h1234, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
